// File: rtl/ysyx_23060061_alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the shared NPC ALU.
// One transaction in flight: IDLE (grant/latch) -> EXEC (drive ALU) -> RESP (hold result).
module ysyx_23060061_alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [3:0]       op_code_q, op_code_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic grant0, grant1;
  logic owner_resp_ready;

  // On a tie the requester that did not win last time is granted.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  assign owner_resp_ready = owner_q ? resp1_ready : resp0_ready;

  // Readies are also gated by rst_n so they read 0 while reset is held.
  assign req0_ready  = rst_n & (state_q == IDLE) & grant0;
  assign req1_ready  = rst_n & (state_q == IDLE) & grant1;
  assign resp0_valid = (state_q == RESP) & ~owner_q;
  assign resp1_valid = (state_q == RESP) &  owner_q;
  assign resp_data   = result_q;
  assign alu_a       = op_a_q;
  assign alu_b       = op_b_q;
  assign alu_op      = op_code_q;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    result_d     = result_q;
    unique case (state_q)
      IDLE: begin
        if (grant0) begin
          op_a_d    = req0_a;
          op_b_d    = req0_b;
          op_code_d = req0_op;
          owner_d   = 1'b0;
          state_d   = EXEC;
        end else if (grant1) begin
          op_a_d    = req1_a;
          op_b_d    = req1_b;
          op_code_d = req1_op;
          owner_d   = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_out;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_resp_ready) begin
          last_grant_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      result_q     <= result_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_alu_arbiter.sv
// Directed bench for the ALU arbiter with a small reference ALU on the alu_* ports.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_ysyx_23060061_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_data, alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned last_start;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU: add, sub, slt, xor, sra; undefined codes return a|b.
  always_comb begin
    case (alu_op)
      4'b0000: alu_out = alu_a + alu_b;
      4'b0011: alu_out = alu_a - alu_b;
      4'b0100: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0110: alu_out = alu_a ^ alu_b;
      4'b0111: alu_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_out = alu_a | alu_b;
    endcase
  end

  ysyx_23060061_alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] op);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  // Called right after a falling edge with requests already driven; expects port p
  // to be granted at the next rising edge and delivers its result exp.
  task automatic serve(input int p, input logic [31:0] exp, input string tag);
    logic [31:0] ea, eb;
    logic [3:0]  eo;
    #1;
    last_start = cyc;
    chk({tag, ":rdy"},   p == 0 ? req0_ready : req1_ready, 1);
    chk({tag, ":nrdy"},  p == 0 ? req1_ready : req0_ready, 0);
    ea = (p == 0) ? req0_a  : req1_a;
    eb = (p == 0) ? req0_b  : req1_b;
    eo = (p == 0) ? req0_op : req1_op;
    @(negedge clk);
    set_req(p, 1'b0, '0, '0, '0);
    #1;
    chk({tag, ":exec_rdy"}, {30'd0, req0_ready, req1_ready}, 0);
    chk({tag, ":exec_vld"}, {30'd0, resp0_valid, resp1_valid}, 0);
    chk({tag, ":alu_a"},  alu_a, ea);
    chk({tag, ":alu_b"},  alu_b, eb);
    chk({tag, ":alu_op"}, {28'd0, alu_op}, {28'd0, eo});
    @(negedge clk);
    #1;
    chk({tag, ":vld"}, {30'd0, resp1_valid, resp0_valid}, (p == 0) ? 32'd1 : 32'd2);
    chk({tag, ":data"}, resp_data, exp);
    if (p == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    #1;
    chk({tag, ":done"}, {30'd0, resp0_valid, resp1_valid}, 0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    #1;
    chk("rst:outs", {28'd0, req0_ready, req1_ready, resp0_valid, resp1_valid}, 0);
    chk("rst:data", resp_data, 0);
    chk("rst:alu",  alu_a | alu_b | {28'd0, alu_op}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single requester, response held until accepted
    @(negedge clk);
    set_req(0, 1'b1, 32'd5, 32'd3, 4'b0000);
    #1;
    chk("t1:rdy0", req0_ready, 1);
    chk("t1:rdy1", req1_ready, 0);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0);
    #1;
    chk("t1:exec_vld", resp0_valid, 0);
    @(negedge clk);
    #1;
    chk("t1:vld0", resp0_valid, 1);
    chk("t1:data", resp_data, 32'd8);
    repeat (3) @(negedge clk);
    #1;
    chk("t1:hold_vld0", resp0_valid, 1);
    chk("t1:hold_vld1", resp1_valid, 0);
    chk("t1:hold_data", resp_data, 32'd8);
    resp0_ready = 1'b1;
    @(negedge clk);
    resp0_ready = 1'b0;
    #1;
    chk("t1:done", resp0_valid, 0);

    // 2: tie after reset goes to req0, then alternates
    do_reset();
    set_req(0, 1'b1, 32'd10, 32'd4, 4'b0011);
    set_req(1, 1'b1, 32'h0F, 32'hF0, 4'b0110);
    serve(0, 32'd6, "t2a");
    set_req(0, 1'b1, 32'd10, 32'd4, 4'b0011);
    serve(1, 32'hFF, "t2b");
    set_req(1, 1'b1, 32'h0F, 32'hF0, 4'b0110);
    serve(0, 32'd6, "t2c");
    set_req(1, 1'b0, '0, '0, '0);

    // 3: backpressure on req1, stray resp0_ready ignored
    set_req(1, 1'b1, 32'd1, 32'd2, 4'b0100);
    #1;
    chk("t3:rdy1", req1_ready, 1);
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0);
    set_req(0, 1'b1, 32'd7, 32'd7, 4'b0000);
    resp0_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3:vld1", resp1_valid, 1);
      chk("t3:vld0", resp0_valid, 0);
      chk("t3:data", resp_data, 32'd1);
      chk("t3:rdy0", req0_ready, 0);
      @(negedge clk);
    end
    resp0_ready = 1'b0;
    resp1_ready = 1'b1;
    @(negedge clk);
    resp1_ready = 1'b0;
    serve(0, 32'd14, "t3b");

    // 4: inputs cleared after accept do not disturb the latched operation
    set_req(0, 1'b1, 32'h8000_0000, 32'd4, 4'b0111);
    serve(0, 32'hF800_0000, "t4");
    // undefined opcode forwarded unchanged
    set_req(1, 1'b1, 32'h30, 32'h0C, 4'b1100);
    serve(1, 32'h3C, "t4u");

    // 5: reset during EXEC aborts, then req0 wins the tie
    set_req(0, 1'b1, 32'd1, 32'd1, 4'b0000);
    #1;
    chk("t5:rdy0", req0_ready, 1);
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 1'b1, 32'd2, 32'd3, 4'b0000);
    set_req(1, 1'b1, 32'd9, 32'd1, 4'b0011);
    #1;
    chk("t5:outs", {28'd0, req0_ready, req1_ready, resp0_valid, resp1_valid}, 0);
    chk("t5:data", resp_data, 0);
    chk("t5:alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    serve(0, 32'd5, "t5a");
    serve(1, 32'd8, "t5b");

    // 6: subtract wrap, then back-to-back req1 issues every 3 cycles
    set_req(1, 1'b1, 32'd0, 32'd1, 4'b0011);
    serve(1, 32'hFFFF_FFFF, "t6");
    for (int i = 0; i < 3; i++) begin
      int unsigned prev;
      prev = last_start;
      set_req(1, 1'b1, 32'd100 + i, i, 4'b0000);
      serve(1, 32'd100 + 2 * i, "t6bb");
      chk("t6:interval", last_start - prev, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
